// File: rtl/shape_processor_modeling_pkg.sv
// rtl/shape_processor_modeling_pkg.sv - shared ctrl SFR types, constants and prediction helpers
//
// Purpose: field layout, legality rules and shadow/request merge for the
// shape processor's control SFR.
// ctrl_sfr_reg layout: [3:0] SHAPE, [7:4] OPERATION, [31:8] reserved (read as 0).
// A field value of all-ones (KEEP_*) means "leave the current value unchanged".
package shape_processor_modeling;

    localparam logic [3:0] SHAPE_CIRCLE   = 4'h1;
    localparam logic [3:0] SHAPE_SQUARE   = 4'h2;
    localparam logic [3:0] SHAPE_TRIANGLE = 4'h3;
    localparam logic [3:0] KEEP_SHAPE     = 4'hF;

    localparam logic [3:0] OP_AREA        = 4'h1;
    localparam logic [3:0] OP_PERIMETER   = 4'h2;
    localparam logic [3:0] OP_SCALE       = 4'h3;
    localparam logic [3:0] KEEP_OPERATION = 4'hF;

    localparam logic [31:0] CTRL_SFR_RESET = {24'h0, OP_AREA, SHAPE_SQUARE};

    typedef enum logic [1:0] {
        ST_APPLIED  = 2'd0,
        ST_REJECTED = 2'd1,
        ST_MISMATCH = 2'd2
    } cmd_status_e;

    function automatic logic is_legal_shape(input logic [3:0] shape);
        return (shape == SHAPE_CIRCLE) || (shape == SHAPE_SQUARE) || (shape == SHAPE_TRIANGLE);
    endfunction

    function automatic logic is_legal_operation(input logic [3:0] op);
        return (op == OP_AREA) || (op == OP_PERIMETER) || (op == OP_SCALE);
    endfunction

    // Triangles cannot be scaled by the processor.
    function automatic logic is_legal_combination(input logic [3:0] shape, input logic [3:0] op);
        return !((shape == SHAPE_TRIANGLE) && (op == OP_SCALE));
    endfunction

    function automatic logic [3:0] resolve_shape(input logic [31:0] shadow, input logic [31:0] wdata);
        return (wdata[3:0] == KEEP_SHAPE) ? shadow[3:0] : wdata[3:0];
    endfunction

    function automatic logic [3:0] resolve_operation(input logic [31:0] shadow, input logic [31:0] wdata);
        return (wdata[7:4] == KEEP_OPERATION) ? shadow[7:4] : wdata[7:4];
    endfunction

    function automatic logic is_legal_request(input logic [31:0] shadow, input logic [31:0] wdata);
        logic [3:0] s;
        logic [3:0] o;
        s = resolve_shape(shadow, wdata);
        o = resolve_operation(shadow, wdata);
        return is_legal_shape(s) && is_legal_operation(o) && is_legal_combination(s, o);
    endfunction

    // Illegal requests are expected to leave the SFR untouched.
    function automatic logic [31:0] predict_ctrl(input logic [31:0] shadow, input logic [31:0] wdata);
        if (is_legal_request(shadow, wdata))
            return {24'h0, resolve_operation(shadow, wdata), resolve_shape(shadow, wdata)};
        else
            return shadow;
    endfunction

endpackage

// File: rtl/shape_ctrl_predictor.sv
// rtl/shape_ctrl_predictor.sv - combinational expected-value and legality predictor
//
// Ports: i_shadow  current shadow copy of ctrl SFR
//        i_wdata   requested write value (KEEP_* allowed)
//        o_expected predicted SFR contents after the write
//        o_legal   request resolves to a legal shape/operation pair
module shape_ctrl_predictor
    import shape_processor_modeling::*;
(
    input  logic [31:0] i_shadow,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_expected,
    output logic        o_legal
);

    assign o_expected = predict_ctrl(i_shadow, i_wdata);
    assign o_legal    = is_legal_request(i_shadow, i_wdata);

endmodule

// File: rtl/shape_ctrl_initiator.sv
// rtl/shape_ctrl_initiator.sv - ctrl SFR write/readback initiator with shadow-based checking
//
// Ports: req_*   request channel (valid/ready, 32-bit ctrl value)
//        resp_*  response channel (valid/ready, status + read-back value)
//        write/write_data, read/read_data, error  processor SFR port set
//        mismatch_count  saturating count of ST_MISMATCH responses
module shape_ctrl_initiator
    import shape_processor_modeling::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [1:0]       resp_status,
    output logic [31:0]      resp_read_data,
    output logic             write,
    output logic [31:0]      write_data,
    output logic             read,
    input  logic [31:0]      read_data,
    input  logic             error,
    output logic [CNT_W-1:0] mismatch_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_WAIT_ERR, S_READ, S_WAIT_RD, S_CHECK, S_RESP
    } state_e;

    localparam logic [1:0] LAT_M1 = (READ_LATENCY > 0) ? 2'(READ_LATENCY - 1) : 2'd0;

    state_e            r_state;
    state_e            w_next_state;
    logic [31:0]       r_req_q;
    logic [31:0]       r_shadow;
    logic [31:0]       r_rd_q;
    logic              r_err_q;
    logic [1:0]        r_cnt;
    cmd_status_e       r_resp_status;
    logic [31:0]       r_resp_read_data;
    logic [CNT_W-1:0]  r_mismatch_count;

    logic [31:0]       w_expected;
    logic              w_legal;
    logic              w_match;
    cmd_status_e       w_status;

    shape_ctrl_predictor u_predictor (
        .i_shadow   (r_shadow),
        .i_wdata    (r_req_q),
        .o_expected (w_expected),
        .o_legal    (w_legal)
    );

    assign w_match  = (r_rd_q == w_expected);
    assign w_status = (w_match && w_legal && !r_err_q)  ? ST_APPLIED  :
                      (w_match && !w_legal && r_err_q)  ? ST_REJECTED : ST_MISMATCH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Strobes are decoded straight from the state register so an async
    // reset removes them without waiting for a clock edge.
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        write        = 1'b0;
        write_data   = '0;
        read         = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next_state = S_WRITE;
            end
            S_WRITE: begin
                write        = 1'b1;
                write_data   = r_req_q;
                w_next_state = S_WAIT_ERR;
            end
            S_WAIT_ERR: w_next_state = S_READ;
            S_READ: begin
                read         = 1'b1;
                w_next_state = (READ_LATENCY == 0) ? S_CHECK : S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (r_cnt == 2'd0) w_next_state = S_CHECK;
            end
            S_CHECK: w_next_state = S_RESP;
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_q          <= '0;
            r_shadow         <= CTRL_SFR_RESET;
            r_rd_q           <= '0;
            r_err_q          <= 1'b0;
            r_cnt            <= '0;
            r_resp_status    <= ST_APPLIED;
            r_resp_read_data <= '0;
            r_mismatch_count <= '0;
        end else begin
            case (r_state)
                S_IDLE:     if (req_valid) r_req_q <= req_data;
                S_WRITE:    r_err_q <= error;
                S_WAIT_ERR: r_err_q <= r_err_q | error;
                S_READ: begin
                    if (READ_LATENCY == 0)
                        r_rd_q <= read_data;
                    else
                        r_cnt <= LAT_M1;
                end
                S_WAIT_RD: begin
                    if (r_cnt == 2'd0)
                        r_rd_q <= read_data;
                    else
                        r_cnt <= r_cnt - 2'd1;
                end
                S_CHECK: begin
                    r_resp_status    <= w_status;
                    r_resp_read_data <= r_rd_q;
                    r_shadow         <= r_rd_q;
                    if (w_status == ST_MISMATCH && r_mismatch_count != '1)
                        r_mismatch_count <= r_mismatch_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign resp_status    = r_resp_status;
    assign resp_read_data = r_resp_read_data;
    assign mismatch_count = r_mismatch_count;

endmodule
